// File: rtl/msx_bus_initiator.sv
// rtl/msx_bus_initiator.sv - Z80-style MSX cartridge bus master (memory, M1, I/O cycles).
// Optional wait timeout abort: define MSX_BUS_TIMEOUT_EN.
module msx_bus_initiator #(
   parameter int CLK_DIV  = 6,
   parameter int WAIT_MAX = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic        req_io,
   input  logic        req_m1,
   input  logic        req_slot,
   input  logic [15:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        rsp_err,
   output logic [15:0] addr,
   output logic [7:0]  cdout,
   output logic        data_oe,
   input  logic [7:0]  cdin,
   output logic        sltsl_n,
   output logic        merq_n,
   output logic        iorq_n,
   output logic        m1_n,
   output logic        rd_n,
   output logic        wr_n,
   input  logic        wait_n
);

   typedef enum logic [2:0] {
      S_IDLE, S_T1, S_T2, S_TW, S_T3, S_DONE
   } state_t;

   if (CLK_DIV < 2 || CLK_DIV > 255 || WAIT_MAX < 1) begin : g_bad_param
      $error("msx_bus_initiator: CLK_DIV must be 2..255 and WAIT_MAX >= 1");
   end

   state_t      r_state;
   logic [7:0]  r_div;
   logic        r_write;
   logic        r_io;
   logic        w_tick;
   logic        w_busy;

   assign w_tick = (r_div == 8'(CLK_DIV - 1));
   assign w_busy = (r_state != S_IDLE) && (r_state != S_DONE);

`ifdef MSX_BUS_TIMEOUT_EN
   logic [15:0] r_wait_cnt;
   logic        r_err;
   assign rsp_err = r_err;
`else
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_div     <= 8'd0;
         r_write   <= 1'b0;
         r_io      <= 1'b0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= 8'd0;
         addr      <= 16'd0;
         cdout     <= 8'd0;
         data_oe   <= 1'b0;
         sltsl_n   <= 1'b1;
         merq_n    <= 1'b1;
         iorq_n    <= 1'b1;
         m1_n      <= 1'b1;
         rd_n      <= 1'b1;
         wr_n      <= 1'b1;
`ifdef MSX_BUS_TIMEOUT_EN
         r_wait_cnt <= 16'd0;
         r_err      <= 1'b0;
`endif
      end else begin
         rsp_valid <= 1'b0;
         if (w_busy) begin
            r_div <= w_tick ? 8'd0 : r_div + 8'd1;
         end
         case (r_state)
            S_IDLE: begin
               if (req_valid && req_ready) begin
                  r_write   <= req_write;
                  r_io      <= req_io;
                  addr      <= req_addr;
                  cdout     <= req_wdata;
                  req_ready <= 1'b0;
                  r_div     <= 8'd0;
`ifdef MSX_BUS_TIMEOUT_EN
                  r_wait_cnt <= 16'd0;
                  r_err      <= 1'b0;
`endif
                  // Memory cycles open their strobes in T1; I/O only presents the address.
                  if (!req_io) begin
                     merq_n  <= 1'b0;
                     sltsl_n <= ~req_slot;
                     if (!req_write) begin
                        rd_n <= 1'b0;
                        m1_n <= ~req_m1;
                     end
                  end
                  r_state <= S_T1;
               end
            end
            S_T1: begin
               if (w_tick) begin
                  if (r_io) begin
                     iorq_n <= 1'b0;
                     if (r_write) begin
                        wr_n    <= 1'b0;
                        data_oe <= 1'b1;
                     end else begin
                        rd_n <= 1'b0;
                     end
                  end else if (r_write) begin
                     wr_n    <= 1'b0;
                     data_oe <= 1'b1;
                  end
                  r_state <= S_T2;
               end
            end
            S_T2: begin
               // I/O always inserts one wait state, memory only on request.
               if (w_tick) begin
                  if (!r_io && wait_n) begin
                     if (!r_write) rsp_rdata <= cdin;
                     m1_n    <= 1'b1;
                     r_state <= S_T3;
                  end else begin
                     r_state <= S_TW;
                  end
               end
            end
            S_TW: begin
               if (w_tick) begin
                  if (wait_n) begin
                     if (!r_write) rsp_rdata <= cdin;
                     m1_n    <= 1'b1;
                     r_state <= S_T3;
                  end
`ifdef MSX_BUS_TIMEOUT_EN
                  else if (r_wait_cnt + 16'd1 == 16'(WAIT_MAX)) begin
                     r_err     <= 1'b1;
                     rsp_rdata <= 8'hFF;
                     m1_n      <= 1'b1;
                     r_state   <= S_T3;
                  end else begin
                     r_wait_cnt <= r_wait_cnt + 16'd1;
                  end
`endif
               end
            end
            S_T3: begin
               if (w_tick) begin
                  sltsl_n <= 1'b1;
                  merq_n  <= 1'b1;
                  iorq_n  <= 1'b1;
                  m1_n    <= 1'b1;
                  rd_n    <= 1'b1;
                  wr_n    <= 1'b1;
                  data_oe <= 1'b0;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               rsp_valid <= 1'b1;
               req_ready <= 1'b1;
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_msx_bus_initiator.sv
// tb/tb_msx_bus_initiator.sv - randomized self-checking bench for msx_bus_initiator.
module tb_msx_bus_initiator;

   localparam int D  = 6;
   localparam int WM = 4;
`ifdef MSX_BUS_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic        req_io = 1'b0;
   logic        req_m1 = 1'b0;
   logic        req_slot = 1'b0;
   logic [15:0] req_addr = 16'd0;
   logic [7:0]  req_wdata = 8'd0;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        rsp_err;
   logic [15:0] addr;
   logic [7:0]  cdout;
   logic        data_oe;
   logic [7:0]  cdin = 8'd0;
   logic        sltsl_n, merq_n, iorq_n, m1_n, rd_n, wr_n;
   logic        wait_n = 1'b1;

   int checks = 0;
   int errors = 0;

   msx_bus_initiator #(.CLK_DIV(D), .WAIT_MAX(WM)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_io(req_io), .req_m1(req_m1), .req_slot(req_slot),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .addr(addr), .cdout(cdout), .data_oe(data_oe), .cdin(cdin),
      .sltsl_n(sltsl_n), .merq_n(merq_n), .iorq_n(iorq_n), .m1_n(m1_n),
      .rd_n(rd_n), .wr_n(wr_n), .wait_n(wait_n)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // nw = number of wait_n-low ticks the cartridge asks for after the first point it may wait.
   task automatic run_txn(input bit wr, input bit io, input bit m1, input bit slot,
                          input logic [15:0] a, input logic [7:0] wd, input logic [7:0] din,
                          input int nw, input bit noise);
      int n, lat, lowlim, low_ticks, tw, total, exp_lat;
      bit timed, viol, pulse;
      int c_merq, c_iorq, c_sltsl, c_m1, c_rd, c_wr, c_oe;
      int e_merq, e_iorq, e_sltsl, e_m1, e_rd, e_wr, e_oe;

      @(negedge clk);
      n = 0;
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("ready_before_req", req_ready, 1);
      req_valid = 1'b1; req_write = wr; req_io = io; req_m1 = m1; req_slot = slot;
      req_addr = a; req_wdata = wd; cdin = din; wait_n = 1'b1;
      @(posedge clk);

      lowlim    = io ? (3 + nw) * D : (2 + nw) * D;
      low_ticks = io ? nw : ((nw > 0) ? nw - 1 : 0);
      timed     = TIMEOUT_EN && (low_ticks >= WM);
      tw        = timed ? WM : (io ? 1 + nw : nw);
      total     = (3 + tw) * D;
      exp_lat   = total + 1;

      e_merq = io ? 0 : total;
      e_sltsl = (!io && slot) ? total : 0;
      e_iorq = io ? total - D : 0;
      e_m1   = (!io && !wr && m1) ? total - D : 0;
      e_rd   = wr ? 0 : (io ? total - D : total);
      e_wr   = wr ? total - D : 0;
      e_oe   = e_wr;

      c_merq = 0; c_iorq = 0; c_sltsl = 0; c_m1 = 0; c_rd = 0; c_wr = 0; c_oe = 0;
      viol = 1'b0; lat = -1;
      for (int j = 1; j < 3000; j++) begin
         @(negedge clk);
         if (rsp_valid) begin
            lat = j - 1;
            break;
         end
         c_merq += !merq_n; c_iorq += !iorq_n; c_sltsl += !sltsl_n; c_m1 += !m1_n;
         c_rd += !rd_n; c_wr += !wr_n; c_oe += data_oe;
         if ((!merq_n && !iorq_n) || (!rd_n && !wr_n) || addr !== a || cdout !== wd)
            viol = 1'b1;
         wait_n = (j < lowlim) ? 1'b0 : 1'b1;
         if (noise && j >= 2 && j < 2 * D) begin
            req_valid = 1'b1;
            req_addr  = 16'($urandom);
         end else begin
            req_valid = 1'b0;
         end
      end
      req_valid = 1'b0;
      wait_n = 1'b1;
      check("latency", lat, exp_lat);
      check("merq_low_clks", c_merq, e_merq);
      check("iorq_low_clks", c_iorq, e_iorq);
      check("sltsl_low_clks", c_sltsl, e_sltsl);
      check("m1_low_clks", c_m1, e_m1);
      check("rd_low_clks", c_rd, e_rd);
      check("wr_low_clks", c_wr, e_wr);
      check("data_oe_clks", c_oe, e_oe);
      check("bus_rules", viol, 0);
      check("addr_held", addr, a);
      check("cdout_held", cdout, wd);
      check("rsp_err", rsp_err, timed);
      if (!wr) check("rsp_rdata", rsp_rdata, timed ? 8'hFF : din);
      @(negedge clk);
      pulse = rsp_valid;
      check("rsp_single_pulse", pulse, 0);
      check("strobes_idle", {sltsl_n, merq_n, iorq_n, m1_n, rd_n, wr_n, data_oe}, 7'h7E);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_strobes", {sltsl_n, merq_n, iorq_n, m1_n, rd_n, wr_n}, 6'h3F);
      check("rst_data_oe", data_oe, 0);
      check("rst_addr", addr, 16'd0);
      check("rst_cdout", cdout, 8'd0);
      check("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 10'd0);
      check("rst_ready", req_ready, 1);
      reset = 1'b0;

      run_txn(0, 0, 0, 1, 16'h4000, 8'h00, 8'h5A, 0, 0);
      run_txn(1, 0, 0, 1, 16'h5000, 8'h03, 8'h00, 0, 0);
      run_txn(0, 1, 0, 0, 16'h008E, 8'h00, 8'hC3, 0, 0);
      run_txn(0, 0, 1, 1, 16'h6000, 8'h00, 8'h77, 3, 1);
      run_txn(1, 1, 0, 0, 16'h0098, 8'hA5, 8'h00, 2, 1);

      // Reset during T2 of a memory write.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_io = 1'b0; req_slot = 1'b1;
      req_addr = 16'h7000; req_wdata = 8'h11;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (D + 1) @(negedge clk);
      check("pre_reset_wr", wr_n, 0);
      #2 reset = 1'b1;
      #1;
      check("midrst_strobes", {sltsl_n, merq_n, iorq_n, m1_n, rd_n, wr_n}, 6'h3F);
      check("midrst_data_oe", data_oe, 0);
      check("midrst_ready", req_ready, 1);
      @(negedge clk);
      reset = 1'b0;
      begin
         int seen;
         seen = 0;
         repeat (5 * D) begin
            @(negedge clk);
            seen += rsp_valid;
         end
         check("no_rsp_after_reset", seen, 0);
      end
      run_txn(0, 0, 0, 1, 16'h7001, 8'h00, 8'h3C, 1, 0);

      if (TIMEOUT_EN) begin
         run_txn(0, 0, 0, 1, 16'h4100, 8'h00, 8'h12, 100, 0);
         run_txn(0, 1, 0, 0, 16'h00A0, 8'h00, 8'h34, 100, 0);
      end

      for (int k = 0; k < 20; k++) begin
         run_txn($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1), 16'($urandom), 8'($urandom), 8'($urandom),
                 $urandom_range(0, 3), $urandom_range(0, 1));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
